// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// word/step widths, default reset PC and a PC alignment helper.
package fetch_pkg;
  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int BUF_DEPTH = 2;

  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~(PC_W'(3));
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO holding fetched {instr, pc} pairs for decode.
// Flush empties it in one cycle; pointers/count are reset, storage is not.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W = INSTR_W + PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);
  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != FULL_CNT) && !flush;
  assign do_pop  = pop && (count != 2'd0) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory request, 2-entry decode buffer,
// redirect with drop of an in-flight stale response.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);
  localparam logic [PC_W-1:0] RST_PC   = word_align(RESET_PC);
  localparam logic [1:0]      FULL_CNT = 2'(BUF_DEPTH);

  fetch_state_e                state_q;
  fetch_state_e                state_d;
  logic [PC_W-1:0]             pc_q;
  logic [PC_W-1:0]             pc_d;
  logic [PC_W-1:0]             drop_addr_q;
  logic [PC_W-1:0]             drop_addr_d;
  logic [1:0]                  count;
  logic [1:0]                  count_next;
  logic                        space_next;
  logic                        buf_valid;
  logic                        push;
  logic                        pop;
  logic [INSTR_W+PC_W-1:0]     head;

  // Redirect wins over everything: no push, no pop, buffer flushed.
  assign buf_valid  = (count != 2'd0);
  assign pop        = buf_valid && dec_ready && !redirect_valid;
  assign push       = (state_q == REQ) && imem_ack && !redirect_valid;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign space_next = (count_next < FULL_CNT);

  fetch_buffer #(
    .DATA_W (INSTR_W + PC_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, pc_q}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
      // An unanswered request must still complete at its old address.
      if ((state_q != IDLE) && !imem_ack) begin
        state_d = DROP;
        if (state_q == REQ) drop_addr_d = pc_q;
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        IDLE: if (space_next) state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + PC_STEP;
            if (!space_next) state_d = IDLE;
          end
        end
        DROP: if (imem_ack) state_d = space_next ? REQ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    drop_addr_q <= drop_addr_d;
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

  assign dec_valid = buf_valid;
  assign dec_instr = buf_valid ? head[INSTR_W+PC_W-1:PC_W] : '0;
  assign dec_pc    = buf_valid ? head[PC_W-1:0] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, stream scoreboard and
// directed/random stimulus.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] restart_pc;
  int          restart_tok;
  logic        mem_force;
  logic        rand_mode;
  int          fix_delay;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    restart_pc = pc & ~32'h3;
    restart_tok++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Responds to requests after 0..N wait cycles; ack driven just after the edge.
  task automatic mem_loop();
    int wait_cnt;
    int cur_delay;
    wait_cnt  = 0;
    cur_delay = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_force) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
      end else if (!rst_n || !imem_req) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt   = 0;
      end else if (wait_cnt >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
        cur_delay  = rand_mode ? int'($urandom_range(0, 3)) : fix_delay;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt++;
      end
    end
  endtask

  // Expected decode stream: consecutive words from the last start point.
  task automatic monitor_loop();
    logic        pend;
    logic [31:0] pend_addr;
    logic        flush_seen;
    int          seen_tok;
    logic [31:0] e;
    pend = 1'b0; pend_addr = '0; flush_seen = 1'b0; seen_tok = 0;
    forever begin
      @(negedge clk);
      if (restart_tok != seen_tok) begin
        seen_tok = restart_tok;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(restart_pc + 32'(4 * i));
      end
      if (!rst_n) begin
        pend = 1'b0;
        flush_seen = 1'b0;
      end else begin
        if (pend) chk("req_stable", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, pend_addr});
        if (flush_seen) chk("flush_empty", 64'(dec_valid), 64'd0);
        if (imem_req) chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
        if (dec_valid && dec_ready && !redirect_valid) begin
          chk("stream_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stream_pc", 64'(dec_pc), 64'(e));
            chk("stream_instr", 64'(dec_instr), 64'(mem_word(e)));
            if (exp_q.size() < 8) exp_q.push_back(e + 32'(4 * (exp_q.size() + 1)));
          end
        end
        pend       = imem_req && !imem_ack;
        pend_addr  = imem_addr;
        flush_seen = redirect_valid;
      end
    end
  endtask

  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0;
    dec_ready = rdy;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'(RST_PC));
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_instr", 64'(dec_instr), 64'd0);
    chk("rst_pc", 64'(dec_pc), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    restart(RST_PC);
    mem_force = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_req", 64'(imem_req), 64'd1);
    chk("rel_addr", 64'(imem_addr), 64'(RST_PC));
  endtask

  initial begin
    int t;
    int gap;
    logic [31:0] a;
    rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; dec_ready = 1'b0; mem_force = 1'b0; rand_mode = 1'b0;
    fix_delay = 0; restart_pc = RST_PC; restart_tok = 0;
    fork
      mem_loop();
      monitor_loop();
    join_none
    #3;

    // Backpressure: two words buffered, request stops, then drain in order.
    apply_reset(1'b0);
    repeat (5) tick();
    chk("stall_req_low", 64'(imem_req), 64'd0);
    chk("stall_valid", 64'(dec_valid), 64'd1);
    chk("stall_pc_held", 64'(dec_pc), 64'(RST_PC));
    dec_ready = 1'b1;
    tick();
    chk("resume_req", 64'(imem_req), 64'd1);
    chk("resume_addr", 64'(imem_addr), 64'(RST_PC + 32'd8));
    chk("drain_second", 64'(dec_pc), 64'(RST_PC + 32'd4));

    // Zero-wait throughput from reset.
    apply_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tput_valid", 64'(dec_valid), 64'd1);
      chk("tput_pc", 64'(dec_pc), 64'(RST_PC + 32'(4 * i)));
    end

    // Three wait cycles per request.
    fix_delay = 3;
    tick();
    t = 0;
    while (!imem_ack && t < 20) begin tick(); t++; end
    chk("ack1_seen", 64'(t < 20), 64'd1);
    tick();
    gap = 0;
    while (!imem_ack && gap < 20) begin
      chk("wait_req_high", 64'(imem_req), 64'd1);
      tick();
      gap++;
    end
    chk("ack_gap", 64'(gap), 64'd3);
    a = imem_addr;
    tick();
    chk("ack_lat_valid", 64'(dec_valid), 64'd1);
    chk("ack_lat_pc", 64'(dec_pc), 64'(a));

    // Redirect while a request is outstanding.
    t = 0;
    while (!(imem_req && !imem_ack) && t < 20) begin tick(); t++; end
    chk("pending_seen", 64'(t < 20), 64'd1);
    a = imem_addr;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; restart(32'h0000_0043);
    tick();
    redirect_valid = 1'b0;
    chk("drop_flush", 64'(dec_valid), 64'd0);
    chk("drop_req", 64'(imem_req), 64'd1);
    chk("drop_addr_old", 64'(imem_addr), 64'(a));
    t = 0;
    while (!dec_valid && t < 30) begin tick(); t++; end
    chk("redir_target", 64'(dec_pc), 64'h40);

    // Redirect coinciding with ack and pop.
    fix_delay = 0;
    t = 0;
    while (!(imem_ack && dec_valid) && t < 40) begin tick(); t++; end
    chk("ackpop_seen", 64'(t < 40), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; restart(32'h0000_0200);
    tick();
    redirect_valid = 1'b0;
    chk("ackpop_flush", 64'(dec_valid), 64'd0);
    t = 0;
    while (!dec_valid && t < 30) begin tick(); t++; end
    chk("ackpop_target", 64'(dec_pc), 64'h200);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; restart(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    t = 0;
    while (!dec_valid && t < 30) begin tick(); t++; end
    chk("wrap_top", 64'(dec_pc), 64'hFFFF_FFFC);
    tick();
    chk("wrap_valid", 64'(dec_valid), 64'd1);
    chk("wrap_zero", 64'(dec_pc), 64'h0);

    // Asynchronous reset mid-request; stray acks around reset are ignored.
    fix_delay = 3;
    tick();
    t = 0;
    while (!(imem_req && !imem_ack) && t < 20) begin tick(); t++; end
    chk("rst_pending_seen", 64'(t < 20), 64'd1);
    #1;
    mem_force = 1'b1;
    apply_reset(1'b1);
    t = 0;
    while (!dec_valid && t < 30) begin tick(); t++; end
    chk("post_rst_pc", 64'(dec_pc), 64'(RST_PC));
    chk("post_rst_instr", 64'(dec_instr), 64'(mem_word(RST_PC)));

    // Random backpressure, latency and redirects.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      dec_ready = ($urandom_range(0, 3) != 0);
      if (redirect_valid) begin
        redirect_valid = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        restart(redirect_pc);
      end
    end
    tick();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    rand_mode = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned PC loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: imem_req  out  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  out  32  byte address of requested word, bits [1:0] always 0.
REQ-006 Port: imem_ack  in  1  memory returns imem_rdata for the current request; may be high in the same cycle as imem_req (zero-wait).
REQ-007 Port: imem_rdata  in  32  fetched instruction word, valid when imem_ack=1.
REQ-008 Port: redirect_valid  in  1  branch/jump taken; one-cycle pulse.
REQ-009 Port: redirect_pc  in  32  new fetch target; bits [1:0] forced to 0 internally.
REQ-010 Port: dec_valid  out  1  dec_instr/dec_pc hold a valid word for decode.
REQ-011 Port: dec_instr  out  32  instruction word to decode (controlUnit/register/ALUControl fields).
REQ-012 Port: dec_pc  out  32  address the word was fetched from.
REQ-013 Port: dec_ready  in  1  decode accepts the word this cycle.

Function
REQ-014 Internal fetch PC pc_q shall advance by 4 on every accepted imem_ack, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-015 At most one memory request shall be outstanding; imem_req and imem_addr shall stay stable from assertion until the cycle imem_ack=1.
REQ-016 The FSM shall have states IDLE, REQ, DROP; IDLE -> REQ when buffer free slots > 0; REQ -> IDLE on ack when buffer becomes full; REQ stays REQ on ack when space remains (issuing pc_q+4 next cycle); REQ -> DROP on redirect_valid without same-cycle ack; DROP -> REQ (or IDLE if no space) on imem_ack.
REQ-017 In DROP, imem_req shall remain high at the old address and the returned word shall be discarded.
REQ-018 A 2-entry in-order buffer shall hold {instr, pc}; dec_valid=1 iff buffer non-empty; head entry pops when dec_valid && dec_ready.
REQ-019 A request shall issue only when (entries + outstanding) < 2; a push never targets a full buffer.
REQ-020 Push and pop in the same cycle shall both occur, entry count unchanged.
REQ-021 On redirect_valid: buffer flushed (dec_valid=0 next cycle), pc_q <= {redirect_pc[31:2],2'b00}, any same-cycle ack data and pop are discarded; redirect has priority over all other events.
REQ-022 Zero-wait memory with dec_ready held high shall sustain one instruction per cycle.
REQ-023 Latency: imem_ack at edge N -> dec_valid=1 with that word after edge N.

Reset
REQ-024 While rst_n=0: pc_q=RESET_PC, FSM=IDLE, buffer empty, imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
REQ-025 Reset asserted mid-request shall abandon the request; any later imem_ack shall be ignored until imem_req is reasserted.
REQ-026 First rising edge after rst_n deassertion shall move FSM to REQ, imem_req=1 at RESET_PC.

Structure
REQ-027 Package fetch_pkg shall hold the FSM state enumeration, INSTR_W=32, PC_STEP=4 and the default RESET_PC.
REQ-028 Buffer shall be a separate sub-module fetch_buffer (2-entry synchronous FIFO with flush, push, pop, count).

Verification
REQ-029 Reset release, zero-wait memory, dec_ready=1 -> dec_pc sequence 0x0,0x4,0x8 on consecutive cycles, one word per cycle.
REQ-030 dec_ready=0 for 5 cycles -> two words buffered, imem_req=0, dec_pc held at 0x0; dec_ready=1 -> 0x0,0x4 drained in order, fetch resumes at 0x8.
REQ-031 Ack delayed 3 cycles -> imem_req/imem_addr stable all 3 cycles; word appears one cycle after ack.
REQ-032 redirect_valid with redirect_pc=0x0000_0043 while request outstanding -> DROP, stale word never seen on dec_*, next dec_pc=0x0000_0040.
REQ-033 redirect_valid same cycle as ack and pop -> flushed, dec_valid=0 next cycle, next fetch from redirect target.
REQ-034 redirect_pc=0xFFFF_FFFC -> dec_pc 0xFFFF_FFFC then 0x0000_0000; rst_n pulse mid-request -> outputs return to reset values asynchronously.
